// File: rtl/router_ctx_pkg.sv
// Shared types and constants for the context-switched router.
// Holds the default flit type, extra port offsets and the stored context record.
package SMARTPkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int NUM_DIR_DEF    = 4;
   localparam int NUM_CTX_DEF    = 8;

   // Offsets of the non-neighbour ports, counted from NUM_DIR
   localparam int ALU_T     = 0;
   localparam int TREG      = 1;
   localparam int LOCAL     = 2;
   localparam int NUM_EXTRA = 3;

   localparam int NUM_IO_DEF = NUM_DIR_DEF + NUM_EXTRA;

   typedef struct packed {
      logic                      valid;
      logic [DATA_WIDTH_DEF-1:0] data;
   } FlitFixed;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } router_state_e;

   typedef struct packed {
      logic [NUM_IO_DEF-1:0][NUM_IO_DEF-1:0] sel;
      logic [NUM_DIR_DEF-1:0]                bypass;
   } RouterCtx;

   // True when more than one bit is set
   function automatic logic multi_hot(input logic [31:0] v);
      return (v & (v - 32'd1)) != 32'd0;
   endfunction

endpackage

// File: rtl/router_xbar.sv
// One-hot crossbar with malformed-row detection.
// A row with more than one bit set is muted and raises err_o.
module router_xbar
   import SMARTPkg::*;
#(
   parameter int W       = 17,
   parameter int NUM_IN  = 7,
   parameter int NUM_OUT = 7
) (
   input  logic [NUM_OUT-1:0][NUM_IN-1:0] sel_i,
   input  logic [NUM_IN-1:0][W-1:0]       in_i,
   output logic [NUM_OUT-1:0][W-1:0]      out_o,
   output logic                           err_o
);

   // Route each output from its single selected input; zero rows stay silent
   always_comb begin
      out_o = '0;
      err_o = 1'b0;
      for (int j = 0; j < NUM_OUT; j++) begin
         if (multi_hot(32'(sel_i[j]))) begin
            err_o = 1'b1;
         end else begin
            for (int i = 0; i < NUM_IN; i++) begin
               if (sel_i[j][i]) out_o[j] = in_i[i];
            end
         end
      end
   end

endmodule

// File: rtl/router_ctx.sv
// Context-sequenced router: FSM, context store, per-direction flit registers.
// Optional ROUTER_PERF_CNT_EN adds a saturating valid-load counter.
module router_ctx
   import SMARTPkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_DIR    = 4,
   parameter int NUM_CTX    = 8,
   localparam int LOG_CTX   = $clog2(NUM_CTX),
   localparam int NUM_IO    = NUM_DIR + NUM_EXTRA,
   localparam int FW        = DATA_WIDTH + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i__cfg_we,
   input  logic [LOG_CTX-1:0]             i__cfg_addr,
   input  logic [NUM_IO-1:0][NUM_IO-1:0]  i__cfg_sel,
   input  logic [NUM_DIR-1:0]             i__cfg_bypass,
   input  logic                           i__start,
   input  logic                           i__stall,
   input  logic [LOG_CTX-1:0]             i__ctx_last,
   input  logic [NUM_DIR-1:0][FW-1:0]     i__flit_in,
   input  logic [FW-1:0]                  i__alu_out,
   input  logic [FW-1:0]                  i__treg,
   input  logic [FW-1:0]                  i__treg1,
   output logic [NUM_IO-1:0][FW-1:0]      o__flit_out,
   output logic [NUM_DIR-1:0][FW-1:0]     o__flit_reg,
   output logic                           o__busy,
   output logic [LOG_CTX-1:0]             o__ctx,
   output logic                           o__err,
   output logic [31:0]                    o__perf_cnt
);

   router_state_e state_q;
   logic          busy_q;
   logic [LOG_CTX-1:0] ctx_q;
   logic [LOG_CTX-1:0] ctx_d;

   logic [NUM_CTX-1:0][NUM_IO-1:0][NUM_IO-1:0] sel_mem_q;
   logic [NUM_CTX-1:0][NUM_DIR-1:0]            byp_mem_q;

   logic [NUM_DIR-1:0][FW-1:0] freg_q;
   logic                       err_q;

   logic [NUM_IO-1:0][NUM_IO-1:0] row_act;
   logic [NUM_DIR-1:0]            byp_act;
   logic [NUM_IO-1:0][FW-1:0]     xin;
   logic                          xerr;
   logic                          adv;

   assign ctx_d = (ctx_q == i__ctx_last) ? '0 : ctx_q + 1'b1;
   assign adv   = (state_q == ST_RUN) && !i__stall;

   // Run/idle sequencing with registered busy and context index
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         ctx_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i__start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!i__start) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  ctx_q   <= '0;
               end else if (!i__stall) begin
                  ctx_q <= ctx_d;
               end
            end
         endcase
      end
   end

   // Context store; reads are combinational so a write lands next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_mem_q <= '0;
         byp_mem_q <= '0;
      end else if (i__cfg_we) begin
         sel_mem_q[i__cfg_addr] <= i__cfg_sel;
         byp_mem_q[i__cfg_addr] <= i__cfg_bypass;
      end
   end

   assign row_act = (state_q == ST_RUN) ? sel_mem_q[ctx_q] : '0;
   assign byp_act = byp_mem_q[ctx_q];

   // Neighbour inputs come live when bypassed, else from the local register
   always_comb begin
      xin = '0;
      for (int d = 0; d < NUM_DIR; d++) begin
         xin[d] = byp_act[d] ? i__flit_in[d] : freg_q[d];
      end
      xin[NUM_DIR+ALU_T] = i__alu_out;
      xin[NUM_DIR+TREG]  = i__treg;
      xin[NUM_DIR+LOCAL] = i__treg1;
   end

   router_xbar #(
      .W       (FW),
      .NUM_IN  (NUM_IO),
      .NUM_OUT (NUM_IO)
   ) u_xbar (
      .sel_i (row_act),
      .in_i  (xin),
      .out_o (o__flit_out),
      .err_o (xerr)
   );

   // Directional registers capture only routed outputs while advancing
   always_ff @(posedge clk) begin
      if (reset) begin
         freg_q <= '0;
      end else if (adv) begin
         for (int d = 0; d < NUM_DIR; d++) begin
            if (|row_act[d]) freg_q[d] <= o__flit_out[d];
         end
      end
   end

   // Sticky malformed-row flag
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (xerr) begin
         err_q <= 1'b1;
      end
   end

`ifdef ROUTER_PERF_CNT_EN
   logic [31:0] perf_q;
   logic        vld_load;

   // Any directional register taking a valid flit this cycle
   always_comb begin
      vld_load = 1'b0;
      for (int d = 0; d < NUM_DIR; d++) begin
         if (adv && (|row_act[d]) && o__flit_out[d][FW-1]) vld_load = 1'b1;
      end
   end

   // Saturating count of cycles with a valid load
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= '0;
      end else if (vld_load && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign o__perf_cnt = perf_q;
`else
   assign o__perf_cnt = '0;
`endif

   assign o__busy     = busy_q;
   assign o__ctx      = ctx_q;
   assign o__err      = err_q;
   assign o__flit_reg = freg_q;

endmodule

// File: tb/tb_router_ctx.sv
// Scoreboard bench for router_ctx: directed scenarios then random traffic.
// Expected outputs come from a behavioural model; a monitor compares them.
module tb_router_ctx;
   import SMARTPkg::*;

   localparam int DW  = 16;
   localparam int ND  = 4;
   localparam int NC  = 8;
   localparam int NIO = ND + 3;
   localparam int FW  = DW + 1;
   localparam int LC  = 3;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, cfg_we, start, stall;
   logic [LC-1:0] cfg_addr, ctx_last;
   logic [NIO-1:0][NIO-1:0] cfg_sel;
   logic [ND-1:0] cfg_byp;
   logic [ND-1:0][FW-1:0] flit_in;
   logic [FW-1:0] alu, treg, treg1;
   logic [NIO-1:0][FW-1:0] fout;
   logic [ND-1:0][FW-1:0] freg;
   logic busy, err;
   logic [LC-1:0] ctx;
   logic [31:0] perf;

   router_ctx #(.DATA_WIDTH(DW), .NUM_DIR(ND), .NUM_CTX(NC)) dut (
      .clk(clk), .reset(reset),
      .i__cfg_we(cfg_we), .i__cfg_addr(cfg_addr),
      .i__cfg_sel(cfg_sel), .i__cfg_bypass(cfg_byp),
      .i__start(start), .i__stall(stall), .i__ctx_last(ctx_last),
      .i__flit_in(flit_in), .i__alu_out(alu),
      .i__treg(treg), .i__treg1(treg1),
      .o__flit_out(fout), .o__flit_reg(freg),
      .o__busy(busy), .o__ctx(ctx), .o__err(err),
      .o__perf_cnt(perf)
   );

   typedef struct packed {
      logic                   busy;
      logic [LC-1:0]          ctx;
      logic                   err;
      logic [31:0]            perf;
      logic [NIO-1:0][FW-1:0] fout;
      logic [ND-1:0][FW-1:0]  freg;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   bit             m_run;
   int             m_ctx;
   bit [NIO-1:0]   m_sel[NC][NIO];
   bit             m_byp[NC][ND];
   logic [FW-1:0]  m_freg[ND];
   bit             m_err;
   longint         m_perf;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_run = 0;
      m_ctx = 0;
      m_err = 0;
      m_perf = 0;
      for (int c = 0; c < NC; c++) begin
         for (int j = 0; j < NIO; j++) m_sel[c][j] = '0;
         for (int d = 0; d < ND; d++) m_byp[c][d] = 0;
      end
      for (int d = 0; d < ND; d++) m_freg[d] = '0;
   endfunction

   task automatic step();
      exp_t e;
      logic [FW-1:0] src[NIO];
      logic [FW-1:0] o[NIO];
      bit bad;
`ifdef ROUTER_PERF_CNT_EN
      bit vld;
      vld = 0;
`endif
      bad = 0;
      for (int d = 0; d < ND; d++)
         src[d] = m_byp[m_ctx][d] ? flit_in[d] : m_freg[d];
      src[ND+ALU_T] = alu;
      src[ND+TREG]  = treg;
      src[ND+LOCAL] = treg1;
      for (int j = 0; j < NIO; j++) begin
         bit [NIO-1:0] row;
         row = m_run ? m_sel[m_ctx][j] : '0;
         o[j] = '0;
         if ($countones(row) == 1) begin
            for (int i = 0; i < NIO; i++) if (row[i]) o[j] = src[i];
         end else if ($countones(row) > 1) begin
            bad = 1;
         end
      end
      e.busy = m_run;
      e.ctx  = LC'(m_ctx);
      e.err  = m_err;
      e.perf = m_perf[31:0];
      for (int j = 0; j < NIO; j++) e.fout[j] = o[j];
      for (int d = 0; d < ND; d++) e.freg[d] = m_freg[d];
      q.push_back(e);
      if (reset) begin
         model_reset();
      end else begin
         if (m_run && !stall) begin
            for (int d = 0; d < ND; d++) begin
               if (m_sel[m_ctx][d] != 0) begin
                  m_freg[d] = o[d];
`ifdef ROUTER_PERF_CNT_EN
                  if (o[d][FW-1]) vld = 1;
`endif
               end
            end
         end
`ifdef ROUTER_PERF_CNT_EN
         if (vld && m_perf < 64'hFFFF_FFFF) m_perf++;
`endif
         if (bad) m_err = 1;
         if (cfg_we) begin
            for (int j = 0; j < NIO; j++) m_sel[cfg_addr][j] = cfg_sel[j];
            for (int d = 0; d < ND; d++) m_byp[cfg_addr][d] = cfg_byp[d];
         end
         if (!m_run) begin
            if (start) m_run = 1;
         end else if (!start) begin
            m_run = 0;
            m_ctx = 0;
         end else if (!stall) begin
            m_ctx = (m_ctx == int'(ctx_last)) ? 0 : (m_ctx + 1) % NC;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [NIO-1:0][NIO-1:0] s,
                     input logic [ND-1:0] b);
      cfg_we   = 1'b1;
      cfg_addr = LC'(a);
      cfg_sel  = s;
      cfg_byp  = b;
      step();
      cfg_we = 1'b0;
   endtask

   function automatic logic [NIO-1:0] rnd_row();
      int r;
      logic [NIO-1:0] v;
      r = $urandom_range(0, 29);
      v = '0;
      if (r >= 3) begin
         v[$urandom_range(0, NIO-1)] = 1'b1;
      end else if (r == 2) begin
         v[0] = 1'b1;
         v[$urandom_range(1, NIO-1)] = 1'b1;
      end
      return v;
   endfunction

   // Monitor: pop expected outputs and compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("busy", busy, e.busy);
            chk("ctx", ctx, e.ctx);
            chk("err", err, e.err);
            chk("perf", perf, e.perf);
            for (int j = 0; j < NIO; j++)
               chk($sformatf("fout%0d", j), fout[j], e.fout[j]);
            for (int d = 0; d < ND; d++)
               chk($sformatf("freg%0d", d), freg[d], e.freg[d]);
         end
      end
   end

   int tbl_a[7] = '{0, 1, 2, 0, 1, 2, 0};
   int tbl_b[7] = '{0, 1, 2, 2, 0, 1, 2};

   initial begin
      logic [NIO-1:0][NIO-1:0] s;
      logic [FW-1:0] x1;
      reset = 1'b1; cfg_we = 1'b0; start = 1'b0; stall = 1'b0;
      cfg_addr = '0; ctx_last = '0; cfg_sel = '0; cfg_byp = '0;
      flit_in = '0; alu = '0; treg = '0; treg1 = '0;
      @(posedge clk);
      #1;
      model_reset();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ctx", ctx, 0);
      chk("rst_err", err, 0);
      chk("rst_perf", perf, 0);
      step();
      reset = 1'b0;
      step();

      // ALU routed to direction 0, then registered
      s = '0;
      s[0] = NIO'(1) << (ND + ALU_T);
      wr(0, s, '0);
      ctx_last = '0;
      alu = 17'h1_00AB;
      start = 1'b1;
      step();
      step();
      #1;
      chk("alu_fout0", fout[0], 17'h1_00AB);
      chk("alu_freg0", freg[0], 17'h1_00AB);
      start = 1'b0;
      step();

      // Context wrap at ctx_last, then with a stall
      ctx_last = 3'd2;
      start = 1'b1;
      step();
      for (int k = 0; k < 7; k++) begin
         #1;
         chk($sformatf("seq_a%0d", k), ctx, tbl_a[k]);
         step();
      end
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      for (int k = 0; k < 7; k++) begin
         stall = (k == 2);
         #1;
         chk($sformatf("seq_b%0d", k), ctx, tbl_b[k]);
         step();
      end
      stall = 1'b0;
      start = 1'b0;
      step();

      // Non-one-hot row mutes output and latches error
      s = '0;
      s[1] = 7'b0000011;
      wr(0, s, '0);
      ctx_last = '0;
      treg1 = 17'h1_3333;
      start = 1'b1;
      step();
      #1;
      chk("bad_fout1", fout[1], 0);
      step();
      #1;
      chk("bad_err", err, 1);
      s[1] = 7'b0000001;
      wr(0, s, '0);
      step();
      step();
      #1;
      chk("bad_err_sticky", err, 1);
      start = 1'b0;
      step();

      // Non-bypassed input reads the previous local register
      x1 = 17'h1_5A5A;
      alu = x1;
      flit_in[2] = 17'h1_0F0F;
      s = '0;
      s[0] = NIO'(1) << 2;
      s[2] = NIO'(1) << (ND + ALU_T);
      wr(0, s, 4'b0000);
      start = 1'b1;
      step();
      step();
      alu = 17'h0_1234;
      #1;
      chk("byp_fout0", fout[0], x1);
      step();
      #1;
      chk("byp_freg0", freg[0], x1);
      start = 1'b0;
      step();

      // Reset in the middle of a run
      s = '0;
      for (int d = 0; d < ND; d++) s[d] = NIO'(1) << (ND + TREG);
      treg = 17'h1_7777;
      for (int c = 0; c < 6; c++) wr(c, s, '1);
      ctx_last = 3'd5;
      start = 1'b1;
      step();
      step();
      step();
      step();
      #1;
      chk("mid_ctx3", ctx, 3);
      reset = 1'b1;
      cfg_we = 1'b1;
      cfg_addr = 3'd1;
      cfg_sel = '1;
      step();
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_ctx", ctx, 0);
      for (int d = 0; d < ND; d++)
         chk($sformatf("mid_freg%0d", d), freg[d], 0);
      reset = 1'b0;
      cfg_we = 1'b0;
      start = 1'b0;
      step();

      // Five load cycles of valid flits into two directions
      s = '0;
      s[0] = NIO'(1) << (ND + ALU_T);
      s[1] = NIO'(1) << (ND + TREG);
      wr(0, s, '0);
      ctx_last = '0;
      alu = 17'h1_0001;
      treg = 17'h1_0002;
      start = 1'b1;
      step();
      repeat (4) step();
      start = 1'b0;
      step();
      #1;
`ifdef ROUTER_PERF_CNT_EN
      chk("perf5", perf, 5);
`else
      chk("perf0", perf, 0);
`endif

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 99) == 0);
         start    = ($urandom_range(0, 9) != 0);
         stall    = ($urandom_range(0, 4) == 0);
         cfg_we   = ($urandom_range(0, 4) == 0);
         cfg_addr = LC'($urandom);
         for (int j = 0; j < NIO; j++) cfg_sel[j] = rnd_row();
         cfg_byp  = ND'($urandom);
         ctx_last = LC'($urandom);
         for (int d = 0; d < ND; d++) flit_in[d] = FW'($urandom);
         alu   = FW'($urandom);
         treg  = FW'($urandom);
         treg1 = FW'($urandom);
         step();
      end
      reset = 1'b0;
      cfg_we = 1'b0;

      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
